// File: rtl/cmos_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cmos_pkg                                               |
// | Description : Shared widths, default geometry and capture state      |
// |               encoding for the DVP camera front end and ram_ctrl.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cmos_pkg;

  localparam int DVP_W       = 8;
  localparam int PIX_W       = 16;
  localparam int CNT_W       = 10;

  // Default frame geometry; ram_ctrl sizes its ping-pong address from these.
  localparam int H_PIX_DEF   = 640;
  localparam int V_LINES_DEF = 480;

  typedef enum logic {
    SKIP = 1'b0,
    RUN  = 1'b1
  } cap_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cmos_geom_check.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cmos_geom_check                                        |
// | Description : Counts pixels per line and lines per frame, emits      |
// |               frame_done / frame_err at the end of each output frame.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cmos_geom_check
  import cmos_pkg::*;
#(
  parameter int H_PIX   = H_PIX_DEF,
  parameter int V_LINES = V_LINES_DEF
) (
  input  logic cam_pclk,
  input  logic rst,
  input  logic run,
  input  logic pix_valid,
  input  logic href_d1,
  input  logic line_odd,
  input  logic vs_fall,
  output logic frame_done,
  output logic frame_err
);

  localparam logic [CNT_W-1:0] H_PIX_C   = CNT_W'(H_PIX);
  localparam logic [CNT_W-1:0] V_LINES_C = CNT_W'(V_LINES);

  logic             href_d2_q,  href_d2_d;
  logic             vs_fall_q,  vs_fall_d;
  logic [CNT_W-1:0] pix_cnt_q,  pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic             line_bad_q, line_bad_d;
  logic             done_q,     done_d;
  logic             err_q,      err_d;
  logic             href_fall;

  // Line/frame accounting; the vs_fall delay lines done/err up with the gated vsync falling.
  always_comb begin
    href_d2_d  = href_d1;
    vs_fall_d  = vs_fall & run;
    href_fall  = href_d2_q & ~href_d1;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    line_bad_d = line_bad_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    if (href_fall) begin
      pix_cnt_d = '0;
    end else if (pix_valid) begin
      pix_cnt_d = sat_inc(pix_cnt_q);
    end

    if (run && href_fall) begin
      line_cnt_d = sat_inc(line_cnt_q);
      if ((pix_cnt_q != H_PIX_C) || line_odd) begin
        line_bad_d = 1'b1;
      end
    end

    if (vs_fall_q) begin
      done_d     = 1'b1;
      err_d      = line_bad_q | (line_cnt_q != V_LINES_C);
      line_cnt_d = '0;
      line_bad_d = 1'b0;
    end
  end

  // Geometry state registers
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      href_d2_q  <= 1'b0;
      vs_fall_q  <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      line_bad_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      href_d2_q  <= href_d2_d;
      vs_fall_q  <= vs_fall_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      line_bad_q <= line_bad_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign frame_done = done_q;
  assign frame_err  = err_q;

endmodule
`default_nettype wire

// File: rtl/cmos_capture_data.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : cmos_capture_data                                      |
// | Description : DVP sensor capture: frame skip after reset, byte-pair  |
// |               packing into RGB565, gated frame sync outputs.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module cmos_capture_data
  import cmos_pkg::*;
#(
  parameter int FRAME_SKIP = 10,
  parameter int H_PIX      = H_PIX_DEF,
  parameter int V_LINES    = V_LINES_DEF
) (
  input  logic             cam_pclk,
  input  logic             rst,
  input  logic             cam_vsync,
  input  logic             cam_href,
  input  logic [DVP_W-1:0] cam_data,
  output logic             cmos_frame_vsync,
  output logic             cmos_frame_href,
  output logic             cmos_frame_clken,
  output logic [PIX_W-1:0] cmos_frame_data,
  output logic             frame_done,
  output logic             frame_err
);

  localparam int                SKIP_W    = (FRAME_SKIP > 0) ? $clog2(FRAME_SKIP + 1) : 1;
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'(FRAME_SKIP);

  logic              vs_d0_q,     vs_d0_d;
  logic              vs_d1_q,     vs_d1_d;
  logic              href_d0_q,   href_d0_d;
  logic              href_d1_q,   href_d1_d;
  logic [DVP_W-1:0]  data_d0_q,   data_d0_d;
  logic              vs_armed_q,  vs_armed_d;
  cap_state_e        state_q,     state_d;
  logic [SKIP_W-1:0] skip_cnt_q,  skip_cnt_d;
  logic              byte_flag_q, byte_flag_d;
  logic [DVP_W-1:0]  hi_byte_q,   hi_byte_d;
  logic              pix_valid_q, pix_valid_d;
  logic [PIX_W-1:0]  pix_q,       pix_d;
  logic              line_odd_q,  line_odd_d;
  logic              out_vs_q,    out_vs_d;
  logic              out_href_q,  out_href_d;
  logic              out_clken_q, out_clken_d;
  logic [PIX_W-1:0]  out_data_q,  out_data_d;
  logic              vs_rise;
  logic              vs_fall;
  logic              run;

  // Input sampling, vsync edges and frame-skip FSM. vs_armed blocks a
  // "rise" caused by a frame already in progress when reset released.
  always_comb begin
    vs_d0_d    = cam_vsync;
    href_d0_d  = cam_href;
    data_d0_d  = cam_data;
    vs_d1_d    = vs_d0_q;
    href_d1_d  = href_d0_q;
    vs_armed_d = vs_armed_q | ~cam_vsync;
    vs_rise    = vs_d0_q & ~vs_d1_q & vs_armed_q;
    vs_fall    = ~vs_d0_q & vs_d1_q;
    run        = (state_q == RUN);
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    if ((state_q == SKIP) && vs_rise) begin
      if (skip_cnt_q == SKIP_LAST) begin
        state_d = RUN;
      end else begin
        skip_cnt_d = skip_cnt_q + 1'b1;
      end
    end
  end

  // Byte-pair packing; an odd trailing byte is remembered for the line check.
  always_comb begin
    byte_flag_d = 1'b0;
    hi_byte_d   = hi_byte_q;
    pix_valid_d = 1'b0;
    pix_d       = pix_q;
    line_odd_d  = line_odd_q;
    if (run) begin
      if (href_d0_q) begin
        byte_flag_d = ~byte_flag_q;
        if (!byte_flag_q) begin
          hi_byte_d = data_d0_q;
        end else begin
          pix_valid_d = 1'b1;
          pix_d       = {hi_byte_q, data_d0_q};
        end
      end else if (href_d1_q) begin
        line_odd_d = byte_flag_q;
      end
    end
  end

  // Output stage: sync signals one register past d1 so they stay aligned with clken.
  always_comb begin
    out_vs_d    = vs_d1_q & run;
    out_href_d  = href_d1_q & run;
    out_clken_d = pix_valid_q;
    out_data_d  = pix_valid_q ? pix_q : out_data_q;
  end

  // All capture-path registers
  always_ff @(posedge cam_pclk or posedge rst) begin
    if (rst) begin
      vs_d0_q     <= 1'b0;
      vs_d1_q     <= 1'b0;
      href_d0_q   <= 1'b0;
      href_d1_q   <= 1'b0;
      data_d0_q   <= '0;
      vs_armed_q  <= 1'b0;
      state_q     <= SKIP;
      skip_cnt_q  <= '0;
      byte_flag_q <= 1'b0;
      hi_byte_q   <= '0;
      pix_valid_q <= 1'b0;
      pix_q       <= '0;
      line_odd_q  <= 1'b0;
      out_vs_q    <= 1'b0;
      out_href_q  <= 1'b0;
      out_clken_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      vs_d0_q     <= vs_d0_d;
      vs_d1_q     <= vs_d1_d;
      href_d0_q   <= href_d0_d;
      href_d1_q   <= href_d1_d;
      data_d0_q   <= data_d0_d;
      vs_armed_q  <= vs_armed_d;
      state_q     <= state_d;
      skip_cnt_q  <= skip_cnt_d;
      byte_flag_q <= byte_flag_d;
      hi_byte_q   <= hi_byte_d;
      pix_valid_q <= pix_valid_d;
      pix_q       <= pix_d;
      line_odd_q  <= line_odd_d;
      out_vs_q    <= out_vs_d;
      out_href_q  <= out_href_d;
      out_clken_q <= out_clken_d;
      out_data_q  <= out_data_d;
    end
  end

  cmos_geom_check #(
    .H_PIX   (H_PIX),
    .V_LINES (V_LINES)
  ) u_geom_check (
    .cam_pclk   (cam_pclk),
    .rst        (rst),
    .run        (run),
    .pix_valid  (pix_valid_q),
    .href_d1    (href_d1_q),
    .line_odd   (line_odd_q),
    .vs_fall    (vs_fall),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  assign cmos_frame_vsync = out_vs_q;
  assign cmos_frame_href  = out_href_q;
  assign cmos_frame_clken = out_clken_q;
  assign cmos_frame_data  = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_cmos_capture_data.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_cmos_capture_data                                   |
// | Description : Directed bench; instance a skips 2 frames, instance b  |
// |               skips none. Geometry 4 pixels x 2 lines.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_cmos_capture_data;

  logic        cam_pclk = 1'b0;
  logic        rst;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;

  logic        a_vsync, a_href, a_clken, a_done, a_err;
  logic [15:0] a_data;
  logic        b_vsync, b_href, b_clken, b_done, b_err;
  logic [15:0] b_data;

  int n_checks = 0;
  int n_fail   = 0;

  int a_clk_cnt = 0, a_done_cnt = 0, a_err_cnt = 0, a_act_cnt = 0;
  int b_clk_cnt = 0, b_done_cnt = 0, b_err_cnt = 0, b_act_cnt = 0;
  int s_a_clk, s_a_done, s_a_err, s_a_act;
  int s_b_clk, s_b_done, s_b_err, s_b_act;

  cmos_capture_data #(.FRAME_SKIP(2), .H_PIX(4), .V_LINES(2)) dut_a (
    .cam_pclk(cam_pclk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .cmos_frame_vsync(a_vsync), .cmos_frame_href(a_href),
    .cmos_frame_clken(a_clken), .cmos_frame_data(a_data), .frame_done(a_done),
    .frame_err(a_err)
  );

  cmos_capture_data #(.FRAME_SKIP(0), .H_PIX(4), .V_LINES(2)) dut_b (
    .cam_pclk(cam_pclk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .cmos_frame_vsync(b_vsync), .cmos_frame_href(b_href),
    .cmos_frame_clken(b_clken), .cmos_frame_data(b_data), .frame_done(b_done),
    .frame_err(b_err)
  );

  always #5 cam_pclk = ~cam_pclk;

  // Output event counters, sampled on the inactive edge
  always @(negedge cam_pclk) begin
    if (a_clken) a_clk_cnt++;
    if (a_done)  a_done_cnt++;
    if (a_err)   a_err_cnt++;
    if (a_vsync | a_href | a_clken | a_done | a_err) a_act_cnt++;
    if (b_clken) b_clk_cnt++;
    if (b_done)  b_done_cnt++;
    if (b_err)   b_err_cnt++;
    if (b_vsync | b_href | b_clken | b_done | b_err) b_act_cnt++;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge cam_pclk);
  endtask

  task automatic snap();
    s_a_clk = a_clk_cnt; s_a_done = a_done_cnt; s_a_err = a_err_cnt; s_a_act = a_act_cnt;
    s_b_clk = b_clk_cnt; s_b_done = b_done_cnt; s_b_err = b_err_cnt; s_b_act = b_act_cnt;
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] base);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge cam_pclk);
      cam_href = 1'b1;
      cam_data = base + 8'(i);
    end
    @(negedge cam_pclk);
    cam_href = 1'b0;
    cam_data = 8'h00;
    idle(4);
  endtask

  task automatic frame_open();
    @(negedge cam_pclk);
    cam_vsync = 1'b1;
    idle(3);
  endtask

  task automatic frame_close();
    idle(2);
    @(negedge cam_pclk);
    cam_vsync = 1'b0;
    idle(8);
  endtask

  task automatic send_frame(input int nlines, input int nbytes, input logic [7:0] base);
    frame_open();
    for (int l = 0; l < nlines; l++) send_line(nbytes, base + 8'(8 * l));
    frame_close();
  endtask

  task automatic test_reset();
    rst = 1'b1; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    idle(3);
    n_checks++;
    if ({a_vsync, a_href, a_clken, a_data, a_done, a_err} !== 21'd0) begin
      n_fail++; $display("FAIL reset_a: got %h expected 0", {a_vsync, a_href, a_clken, a_data, a_done, a_err});
    end
    n_checks++;
    if ({b_vsync, b_href, b_clken, b_data, b_done, b_err} !== 21'd0) begin
      n_fail++; $display("FAIL reset_b: got %h expected 0", {b_vsync, b_href, b_clken, b_data, b_done, b_err});
    end
    @(negedge cam_pclk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_skip();
    // Frame 1: a silent, b outputs it
    snap(); send_frame(2, 8, 8'h10);
    n_checks++;
    if (a_act_cnt - s_a_act !== 0) begin n_fail++; $display("FAIL skip_f1_a_act: got %0d expected 0", a_act_cnt - s_a_act); end
    n_checks++;
    if (b_clk_cnt - s_b_clk !== 8) begin n_fail++; $display("FAIL skip_f1_b_clken: got %0d expected 8", b_clk_cnt - s_b_clk); end
    n_checks++;
    if (b_done_cnt - s_b_done !== 1 || b_err_cnt - s_b_err !== 0) begin
      n_fail++; $display("FAIL skip_f1_b_done_err: got %0d/%0d expected 1/0", b_done_cnt - s_b_done, b_err_cnt - s_b_err);
    end
    n_checks++;
    if (b_data !== 16'h1E1F) begin n_fail++; $display("FAIL skip_f1_b_data: got %h expected 1e1f", b_data); end
    // Frame 2: a still silent
    snap(); send_frame(2, 8, 8'h20);
    n_checks++;
    if (a_act_cnt - s_a_act !== 0) begin n_fail++; $display("FAIL skip_f2_a_act: got %0d expected 0", a_act_cnt - s_a_act); end
    // Frames 3 and 4: a outputs
    snap(); send_frame(2, 8, 8'h30);
    n_checks++;
    if (a_clk_cnt - s_a_clk !== 8) begin n_fail++; $display("FAIL skip_f3_a_clken: got %0d expected 8", a_clk_cnt - s_a_clk); end
    n_checks++;
    if (a_done_cnt - s_a_done !== 1 || a_err_cnt - s_a_err !== 0) begin
      n_fail++; $display("FAIL skip_f3_a_done_err: got %0d/%0d expected 1/0", a_done_cnt - s_a_done, a_err_cnt - s_a_err);
    end
    n_checks++;
    if (a_data !== 16'h3E3F) begin n_fail++; $display("FAIL skip_f3_a_data: got %h expected 3e3f", a_data); end
    snap(); send_frame(2, 8, 8'h40);
    n_checks++;
    if (a_clk_cnt - s_a_clk !== 8 || a_done_cnt - s_a_done !== 1) begin
      n_fail++; $display("FAIL skip_f4_a: got clken %0d done %0d expected 8/1", a_clk_cnt - s_a_clk, a_done_cnt - s_a_done);
    end
    n_checks++;
    if (a_data !== 16'h4E4F) begin n_fail++; $display("FAIL skip_f4_a_data: got %h expected 4e4f", a_data); end
  endtask

  task automatic test_pixel_timing();
    snap();
    frame_open();
    @(negedge cam_pclk); cam_href = 1'b1; cam_data = 8'hF8;
    @(negedge cam_pclk); cam_data = 8'h1F;
    @(posedge cam_pclk);                        // edge k: 0x1F sampled
    @(negedge cam_pclk); cam_href = 1'b0; cam_data = 8'h00;
    n_checks++;
    if (a_clken !== 1'b0) begin n_fail++; $display("FAIL pix_k0_clken: got %b expected 0", a_clken); end
    @(negedge cam_pclk);
    n_checks++;
    if (a_clken !== 1'b0) begin n_fail++; $display("FAIL pix_k1_clken: got %b expected 0", a_clken); end
    @(negedge cam_pclk);
    n_checks++;
    if (a_clken !== 1'b1 || a_data !== 16'hF81F) begin
      n_fail++; $display("FAIL pix_k2: got clken %b data %h expected 1 f81f", a_clken, a_data);
    end
    n_checks++;
    if (a_href !== 1'b1) begin n_fail++; $display("FAIL pix_k2_href: got %b expected 1", a_href); end
    @(negedge cam_pclk);
    n_checks++;
    if (a_clken !== 1'b0 || a_data !== 16'hF81F || a_href !== 1'b0) begin
      n_fail++; $display("FAIL pix_k3: got clken %b data %h href %b expected 0 f81f 0", a_clken, a_data, a_href);
    end
    idle(3);
    frame_close();
    n_checks++;
    if (a_done_cnt - s_a_done !== 1 || a_err_cnt - s_a_err !== 1) begin
      n_fail++; $display("FAIL pix_frame_done_err: got %0d/%0d expected 1/1", a_done_cnt - s_a_done, a_err_cnt - s_a_err);
    end
  endtask

  task automatic test_odd_line();
    snap();
    frame_open(); send_line(7, 8'h50); send_line(8, 8'h60); frame_close();
    n_checks++;
    if (a_clk_cnt - s_a_clk !== 7) begin n_fail++; $display("FAIL odd7_clken: got %0d expected 7", a_clk_cnt - s_a_clk); end
    n_checks++;
    if (a_done_cnt - s_a_done !== 1 || a_err_cnt - s_a_err !== 1) begin
      n_fail++; $display("FAIL odd7_done_err: got %0d/%0d expected 1/1", a_done_cnt - s_a_done, a_err_cnt - s_a_err);
    end
    n_checks++;
    if (a_data !== 16'h6667) begin n_fail++; $display("FAIL odd7_data: got %h expected 6667", a_data); end
    snap();
    frame_open(); send_line(9, 8'h70); send_line(8, 8'h80); frame_close();
    n_checks++;
    if (a_clk_cnt - s_a_clk !== 8) begin n_fail++; $display("FAIL odd9_clken: got %0d expected 8", a_clk_cnt - s_a_clk); end
    n_checks++;
    if (a_done_cnt - s_a_done !== 1 || a_err_cnt - s_a_err !== 1) begin
      n_fail++; $display("FAIL odd9_done_err: got %0d/%0d expected 1/1", a_done_cnt - s_a_done, a_err_cnt - s_a_err);
    end
  endtask

  task automatic test_line_count();
    snap(); send_frame(3, 8, 8'hA0);
    n_checks++;
    if (a_clk_cnt - s_a_clk !== 12) begin n_fail++; $display("FAIL lines3_clken: got %0d expected 12", a_clk_cnt - s_a_clk); end
    n_checks++;
    if (a_done_cnt - s_a_done !== 1 || a_err_cnt - s_a_err !== 1) begin
      n_fail++; $display("FAIL lines3_done_err: got %0d/%0d expected 1/1", a_done_cnt - s_a_done, a_err_cnt - s_a_err);
    end
    snap(); send_frame(2, 8, 8'hB0);
    n_checks++;
    if (a_done_cnt - s_a_done !== 1 || a_err_cnt - s_a_err !== 0) begin
      n_fail++; $display("FAIL lines2_done_err: got %0d/%0d expected 1/0", a_done_cnt - s_a_done, a_err_cnt - s_a_err);
    end
    n_checks++;
    if (a_data !== 16'hBEBF) begin n_fail++; $display("FAIL lines2_data: got %h expected bebf", a_data); end
  endtask

  task automatic test_reset_midline();
    frame_open();
    for (int i = 0; i < 4; i++) begin
      @(negedge cam_pclk); cam_href = 1'b1; cam_data = 8'hC0 + 8'(i);
    end
    n_checks++;
    if (a_href !== 1'b1) begin n_fail++; $display("FAIL midline_href_before: got %b expected 1", a_href); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({a_vsync, a_href, a_clken, a_data, a_done, a_err} !== 21'd0) begin
      n_fail++; $display("FAIL midline_async_a: got %h expected 0", {a_vsync, a_href, a_clken, a_data, a_done, a_err});
    end
    n_checks++;
    if ({b_vsync, b_href, b_clken, b_data, b_done, b_err} !== 21'd0) begin
      n_fail++; $display("FAIL midline_async_b: got %h expected 0", {b_vsync, b_href, b_clken, b_data, b_done, b_err});
    end
    @(negedge cam_pclk); cam_href = 1'b0; cam_data = 8'h00;
    idle(3);
    @(negedge cam_pclk); rst = 1'b0;
    snap();
    send_line(8, 8'hC8);
    frame_close();
    n_checks++;
    if (a_act_cnt - s_a_act !== 0 || b_act_cnt - s_b_act !== 0) begin
      n_fail++; $display("FAIL midline_partial_act: got a %0d b %0d expected 0 0", a_act_cnt - s_a_act, b_act_cnt - s_b_act);
    end
    snap(); send_frame(2, 8, 8'hD0);
    n_checks++;
    if (a_act_cnt - s_a_act !== 0) begin n_fail++; $display("FAIL midline_f1_a_act: got %0d expected 0", a_act_cnt - s_a_act); end
    n_checks++;
    if (b_clk_cnt - s_b_clk !== 8 || b_done_cnt - s_b_done !== 1) begin
      n_fail++; $display("FAIL midline_f1_b: got clken %0d done %0d expected 8/1", b_clk_cnt - s_b_clk, b_done_cnt - s_b_done);
    end
    snap(); send_frame(2, 8, 8'hD0);
    n_checks++;
    if (a_act_cnt - s_a_act !== 0) begin n_fail++; $display("FAIL midline_f2_a_act: got %0d expected 0", a_act_cnt - s_a_act); end
    snap(); send_frame(2, 8, 8'hD0);
    n_checks++;
    if (a_clk_cnt - s_a_clk !== 8 || a_done_cnt - s_a_done !== 1 || a_err_cnt - s_a_err !== 0) begin
      n_fail++; $display("FAIL midline_f3_a: got clken %0d done %0d err %0d expected 8/1/0",
                         a_clk_cnt - s_a_clk, a_done_cnt - s_a_done, a_err_cnt - s_a_err);
    end
  endtask

  task automatic test_vsync_at_reset();
    @(negedge cam_pclk); cam_vsync = 1'b1;
    idle(2);
    rst = 1'b1;
    idle(3);
    @(negedge cam_pclk); rst = 1'b0;
    snap();
    send_line(8, 8'hE0); send_line(8, 8'hE8);
    frame_close();
    n_checks++;
    if (b_act_cnt - s_b_act !== 0) begin n_fail++; $display("FAIL vsrst_partial_b_act: got %0d expected 0", b_act_cnt - s_b_act); end
    n_checks++;
    if (b_done_cnt - s_b_done !== 0) begin n_fail++; $display("FAIL vsrst_partial_b_done: got %0d expected 0", b_done_cnt - s_b_done); end
    snap(); send_frame(2, 8, 8'hF0);
    n_checks++;
    if (b_clk_cnt - s_b_clk !== 8) begin n_fail++; $display("FAIL vsrst_next_b_clken: got %0d expected 8", b_clk_cnt - s_b_clk); end
    n_checks++;
    if (b_done_cnt - s_b_done !== 1 || b_err_cnt - s_b_err !== 0) begin
      n_fail++; $display("FAIL vsrst_next_b_done_err: got %0d/%0d expected 1/0", b_done_cnt - s_b_done, b_err_cnt - s_b_err);
    end
    n_checks++;
    if (b_data !== 16'hFEFF) begin n_fail++; $display("FAIL vsrst_next_b_data: got %h expected feff", b_data); end
  endtask

  initial begin
    test_reset();
    test_skip();
    test_pixel_timing();
    test_odd_line();
    test_line_count();
    test_reset_midline();
    test_vsync_at_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
